// File: rtl/mem_arbiter_rr.sv
// N-port arbiter serialising byte/half/word accesses onto an 8-bit RAM/IO bus; write done n cycles after grant, read n+1.
// Backpressure: rdy_in low freezes everything; IO-full blocks IO write grants; req_ready pulses once per completion.
module mem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int RR_MODE   = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [31:0]               mem_a,
  output logic                      mem_wr,
  input  logic                      io_buffer_full,
  input  logic [NUM_PORTS-1:0]      req_valid,
  input  logic [NUM_PORTS-1:0]      req_wr,
  input  logic [32*NUM_PORTS-1:0]   req_addr,
  input  logic [3*NUM_PORTS-1:0]    req_len,
  input  logic [32*NUM_PORTS-1:0]   req_data,
  input  logic [NUM_PORTS-1:0]      req_cancel,
  output logic [NUM_PORTS-1:0]      req_ready,
  output logic [31:0]               req_res
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;

  logic [PW-1:0]        ptr_q, gnt_q, sel;
  logic [NUM_PORTS-1:0] elig;
  logic                 any_elig;
  int                   idx;
  logic                 g_wr;
  logic [31:0]          g_addr, g_data;
  logic [2:0]           g_len;
  logic                 wr_q, mem_wr_q;
  logic [31:0]          addr_q, data_q;
  logic [2:0]           len_q;
  logic [1:0]           k_q, n_m1;
  logic [23:0]          rbuf_q;
  logic                 last, cxl, sx;
  logic [31:0]          rd_res;

  always_comb begin
    elig = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig[p] = req_valid[p] && !req_cancel[p] &&
                !((req_addr[32*p+16 +: 2] == 2'b11) && req_wr[p] && io_buffer_full);
    end
  end

  // Search order starts at the pointer in round-robin mode, at port 0 otherwise.
  always_comb begin
    sel      = '0;
    any_elig = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (RR_MODE != 0) ? int'(ptr_q) + i : i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!any_elig && idx == p && elig[p]) begin
          any_elig = 1'b1;
          sel      = PW'(p);
        end
      end
    end
  end

  always_comb begin
    g_wr   = 1'b0;
    g_addr = '0;
    g_data = '0;
    g_len  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel == PW'(p)) begin
        g_wr   = req_wr[p];
        g_addr = req_addr[32*p +: 32];
        g_data = req_data[32*p +: 32];
        g_len  = req_len[3*p +: 3];
      end
    end
  end

  always_comb begin
    case (len_q[1:0])
      2'd1:    n_m1 = 2'd1;
      2'd2:    n_m1 = 2'd3;
      default: n_m1 = 2'd0;
    endcase
    last = (k_q == n_m1);
    cxl  = req_cancel[gnt_q] && !wr_q;
    sx   = len_q[2] && mem_din[7];
    case (len_q[1:0])
      2'd1:    rd_res = {{16{sx}}, mem_din, rbuf_q[7:0]};
      2'd2:    rd_res = {mem_din, rbuf_q};
      default: rd_res = {{24{sx}}, mem_din};
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_elig) state_d = S_XFER;
      S_XFER: begin
        if (cxl)       state_d = S_IDLE;
        else if (last) state_d = wr_q ? S_DONE : S_WAIT;
      end
      S_WAIT: state_d = cxl ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      len_q     <= '0;
      k_q       <= '0;
      rbuf_q    <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr_q  <= 1'b0;
      req_ready <= '0;
      req_res   <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      req_ready <= '0;
      req_res   <= '0;
      case (state_q)
        S_IDLE: if (any_elig) begin
          gnt_q    <= sel;
          ptr_q    <= (sel == PW'(NUM_PORTS-1)) ? '0 : sel + 1'b1;
          wr_q     <= g_wr;
          addr_q   <= g_addr;
          len_q    <= g_len;
          data_q   <= g_data >> 8;
          k_q      <= '0;
          mem_a    <= g_addr;
          mem_dout <= g_data[7:0];
          mem_wr_q <= g_wr;
        end
        S_XFER: begin
          // Read data lags the address by one cycle, so byte k-1 arrives now.
          if (!cxl && !wr_q) begin
            case (k_q)
              2'd1:    rbuf_q[7:0]   <= mem_din;
              2'd2:    rbuf_q[15:8]  <= mem_din;
              2'd3:    rbuf_q[23:16] <= mem_din;
              default: ;
            endcase
          end
          if (cxl || last) begin
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr_q <= 1'b0;
            if (!cxl && wr_q) req_ready[gnt_q] <= 1'b1;
          end else begin
            k_q      <= k_q + 2'd1;
            mem_a    <= addr_q + 32'(k_q) + 32'd1;
            mem_dout <= data_q[7:0];
            data_q   <= data_q >> 8;
          end
        end
        S_WAIT: if (!cxl) begin
          req_ready[gnt_q] <= 1'b1;
          req_res          <= rd_res;
        end
        default: ;
      endcase
    end
  end

  assign mem_wr = mem_wr_q && rdy_in;

endmodule
